// File: rtl/adaptive_phase_controller.sv
// Multi-phase adaptive traffic-signal controller: timed green/yellow/all-red with demand skipping and rest-in-green.
// Optional emergency pre-emption is compiled in when the PREEMPT_EN macro is defined.
module adaptive_phase_controller #(
  parameter int NUM_PHASES   = 4,
  parameter int TIMER_W      = 8,
  parameter int MIN_GREEN    = 4,
  parameter int MAX_GREEN    = 16,
  parameter int YELLOW_TIME  = 3,
  parameter int ALL_RED_TIME = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_PHASES-1:0]         demand,
  input  logic [NUM_PHASES-1:0]         congest,
`ifdef PREEMPT_EN
  input  logic                          preempt_req,
  input  logic [$clog2(NUM_PHASES)-1:0] preempt_phase,
  output logic                          preempt_active,
`endif
  output logic [$clog2(NUM_PHASES)-1:0] phase_id,
  output logic [1:0]                    light,
  output logic [NUM_PHASES-1:0]         green_onehot,
  output logic                          phase_change
);

  localparam int PW = $clog2(NUM_PHASES);

  localparam logic [TIMER_W-1:0] MIN_M1 = TIMER_W'(MIN_GREEN - 1);
  localparam logic [TIMER_W-1:0] MAX_M1 = TIMER_W'(MAX_GREEN - 1);
  localparam logic [TIMER_W-1:0] YEL_M1 = TIMER_W'(YELLOW_TIME - 1);
  localparam logic [TIMER_W-1:0] AR_M1  = TIMER_W'(ALL_RED_TIME - 1);

  localparam logic [1:0] LIGHT_GREEN  = 2'b01;
  localparam logic [1:0] LIGHT_YELLOW = 2'b10;
  localparam logic [1:0] LIGHT_RED    = 2'b00;

  generate
    if (NUM_PHASES < 2)
      $fatal(1, "adaptive_phase_controller: NUM_PHASES must be at least 2");
    if (MIN_GREEN < 1 || MAX_GREEN < MIN_GREEN || YELLOW_TIME < 1 || ALL_RED_TIME < 1)
      $fatal(1, "adaptive_phase_controller: interval parameters out of range");
    if (TIMER_W < 1 || TIMER_W > 30 ||
        (MIN_GREEN >> TIMER_W) != 0 || (MAX_GREEN >> TIMER_W) != 0 ||
        (YELLOW_TIME >> TIMER_W) != 0 || (ALL_RED_TIME >> TIMER_W) != 0)
      $fatal(1, "adaptive_phase_controller: interval parameters exceed TIMER_W");
  endgenerate

  typedef enum logic [1:0] {
    GREEN,
    YELLOW,
    ALL_RED
  } state_t;

  state_t              state;
  logic [TIMER_W-1:0]  cnt;
  logic                other_dem;
  logic                exit_green;
  logic [PW-1:0]       next_phase;
  logic [PW-1:0]       cand;
  logic [PW:0]         sum;

  // Next phase: nearest demanding phase above the current one, the current phase itself only as last resort.
  always_comb begin
    other_dem  = |(demand & ~(NUM_PHASES'(1) << phase_id));
    next_phase = (phase_id == PW'(NUM_PHASES - 1)) ? '0 : phase_id + PW'(1);
    sum        = '0;
    cand       = '0;
    for (int i = NUM_PHASES; i >= 1; i--) begin
      sum = {1'b0, phase_id} + (PW+1)'(i);
      if (sum >= (PW+1)'(NUM_PHASES))
        sum = sum - (PW+1)'(NUM_PHASES);
      cand = sum[PW-1:0];
      if (demand[cand])
        next_phase = cand;
    end
`ifdef PREEMPT_EN
    if (preempt_req)
      next_phase = preempt_phase;
`endif
  end

  always_comb begin
    exit_green = (cnt >= MIN_M1) && other_dem && (!congest[phase_id] || (cnt >= MAX_M1));
`ifdef PREEMPT_EN
    if (preempt_req)
      exit_green = (phase_id != preempt_phase);
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= GREEN;
      phase_id     <= '0;
      cnt          <= '0;
      light        <= LIGHT_GREEN;
      green_onehot <= NUM_PHASES'(1);
      phase_change <= 1'b0;
`ifdef PREEMPT_EN
      preempt_active <= 1'b0;
`endif
    end else begin
      phase_change <= 1'b0;
`ifdef PREEMPT_EN
      preempt_active <= preempt_req;
`endif
      case (state)
        GREEN: begin
          if (exit_green) begin
            state        <= YELLOW;
            cnt          <= '0;
            light        <= LIGHT_YELLOW;
            green_onehot <= '0;
          end else if (cnt < MAX_M1) begin
            cnt <= cnt + TIMER_W'(1);
          end
        end
        YELLOW: begin
          if (cnt == YEL_M1) begin
            state <= ALL_RED;
            cnt   <= '0;
            light <= LIGHT_RED;
          end else begin
            cnt <= cnt + TIMER_W'(1);
          end
        end
        ALL_RED: begin
          if (cnt == AR_M1) begin
            state        <= GREEN;
            cnt          <= '0;
            phase_id     <= next_phase;
            light        <= LIGHT_GREEN;
            green_onehot <= NUM_PHASES'(1) << next_phase;
            phase_change <= 1'b1;
          end else begin
            cnt <= cnt + TIMER_W'(1);
          end
        end
        default: begin
          state        <= GREEN;
          cnt          <= '0;
          phase_id     <= '0;
          light        <= LIGHT_GREEN;
          green_onehot <= NUM_PHASES'(1);
        end
      endcase
    end
  end

endmodule

// File: tb/tb_adaptive_phase_controller.sv
// Scoreboard bench for adaptive_phase_controller: expected per-cycle outputs queued with stimulus, compared as cycles elapse.
// The pre-emption scenario is included only when PREEMPT_EN is defined.
module tb_adaptive_phase_controller;

  localparam logic [1:0] GRN = 2'b01;
  localparam logic [1:0] YEL = 2'b10;
  localparam logic [1:0] RED = 2'b00;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] demand;
  logic [3:0] congest;
  logic [1:0] phase_id;
  logic [1:0] light;
  logic [3:0] green_onehot;
  logic       phase_change;
`ifdef PREEMPT_EN
  logic       preempt_req;
  logic [1:0] preempt_phase;
  logic       preempt_active;
`endif

  typedef struct packed {
    logic [1:0] ph;
    logic [1:0] lt;
    logic [3:0] oh;
    logic       pc;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  adaptive_phase_controller #(
    .NUM_PHASES(4), .TIMER_W(8), .MIN_GREEN(4), .MAX_GREEN(16),
    .YELLOW_TIME(3), .ALL_RED_TIME(1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .demand(demand),
    .congest(congest),
`ifdef PREEMPT_EN
    .preempt_req(preempt_req),
    .preempt_phase(preempt_phase),
    .preempt_active(preempt_active),
`endif
    .phase_id(phase_id),
    .light(light),
    .green_onehot(green_onehot),
    .phase_change(phase_change)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got running, want finished");
    $fatal(1, "[TB] watchdog expired");
  end

  // Queue n cycles of one interval; phase_change is expected only on the first of them.
  task automatic push(input logic [1:0] ph, input logic [1:0] lt, input logic pc, input int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      e.ph = ph;
      e.lt = lt;
      e.oh = (lt == GRN) ? (4'b0001 << ph) : 4'b0000;
      e.pc = (i == 0) ? pc : 1'b0;
      sb.push_back(e);
    end
  endtask

  task automatic do_reset(input logic [3:0] dem, input logic [3:0] cong);
    rst     = 1'b1;
    demand  = 4'($urandom);
    congest = 4'($urandom);
`ifdef PREEMPT_EN
    preempt_req   = 1'($urandom);
    preempt_phase = 2'($urandom);
`endif
    @(posedge clk);
    @(posedge clk);
    #1;
    rst     = 1'b0;
    demand  = dem;
    congest = cong;
`ifdef PREEMPT_EN
    preempt_req   = 1'b0;
    preempt_phase = 2'd0;
`endif
  endtask

  task automatic test_reset();
    do_reset(4'b0000, 4'b0000);
    checks++;
    if ({phase_id, light, green_onehot, phase_change} !== {2'd0, GRN, 4'b0001, 1'b0}) begin
      errors++;
      $display("[TB] FAIL reset: got ph=%0d light=%b oh=%b pc=%b, want ph=0 light=01 oh=0001 pc=0",
               phase_id, light, green_onehot, phase_change);
    end
  endtask

  task automatic test_skip_empty();
    exp_t e;
    do_reset(4'b0100, 4'b0000);
    push(2'd0, GRN, 1'b0, 3);
    push(2'd0, YEL, 1'b0, 3);
    push(2'd0, RED, 1'b0, 1);
    push(2'd2, GRN, 1'b1, 3);
    while (sb.size() > 0) begin
      @(posedge clk); #1;
      e = sb.pop_front();
      checks++;
      if ({phase_id, light, green_onehot, phase_change} !== e) begin
        errors++;
        $display("[TB] FAIL skip_empty: got ph=%0d light=%b oh=%b pc=%b, want ph=%0d light=%b oh=%b pc=%b",
                 phase_id, light, green_onehot, phase_change, e.ph, e.lt, e.oh, e.pc);
      end
    end
  endtask

  task automatic test_max_cap();
    exp_t e;
    do_reset(4'b0010, 4'b0001);
    push(2'd0, GRN, 1'b0, 15);
    push(2'd0, YEL, 1'b0, 3);
    push(2'd0, RED, 1'b0, 1);
    push(2'd1, GRN, 1'b1, 2);
    while (sb.size() > 0) begin
      @(posedge clk); #1;
      e = sb.pop_front();
      checks++;
      if ({phase_id, light, green_onehot, phase_change} !== e) begin
        errors++;
        $display("[TB] FAIL max_cap: got ph=%0d light=%b oh=%b pc=%b, want ph=%0d light=%b oh=%b pc=%b",
                 phase_id, light, green_onehot, phase_change, e.ph, e.lt, e.oh, e.pc);
      end
    end
  endtask

  task automatic test_rest_late_demand();
    exp_t e;
    do_reset(4'b0000, 4'b0000);
    push(2'd0, GRN, 1'b0, 19);
    while (sb.size() > 0) begin
      @(posedge clk); #1;
      e = sb.pop_front();
      checks++;
      if ({phase_id, light, green_onehot, phase_change} !== e) begin
        errors++;
        $display("[TB] FAIL rest_green: got ph=%0d light=%b oh=%b pc=%b, want ph=%0d light=%b oh=%b pc=%b",
                 phase_id, light, green_onehot, phase_change, e.ph, e.lt, e.oh, e.pc);
      end
    end
    demand = 4'b1000;
    push(2'd0, YEL, 1'b0, 3);
    push(2'd0, RED, 1'b0, 1);
    push(2'd3, GRN, 1'b1, 1);
    while (sb.size() > 0) begin
      @(posedge clk); #1;
      e = sb.pop_front();
      checks++;
      if ({phase_id, light, green_onehot, phase_change} !== e) begin
        errors++;
        $display("[TB] FAIL late_demand: got ph=%0d light=%b oh=%b pc=%b, want ph=%0d light=%b oh=%b pc=%b",
                 phase_id, light, green_onehot, phase_change, e.ph, e.lt, e.oh, e.pc);
      end
    end
  endtask

  // Continues from phase 3 green left by the previous scenario.
  task automatic test_wrap_reset();
    exp_t e;
    demand = 4'b0001;
    push(2'd3, GRN, 1'b0, 3);
    push(2'd3, YEL, 1'b0, 3);
    push(2'd3, RED, 1'b0, 1);
    push(2'd0, GRN, 1'b1, 1);
    while (sb.size() > 0) begin
      @(posedge clk); #1;
      e = sb.pop_front();
      checks++;
      if ({phase_id, light, green_onehot, phase_change} !== e) begin
        errors++;
        $display("[TB] FAIL wrap: got ph=%0d light=%b oh=%b pc=%b, want ph=%0d light=%b oh=%b pc=%b",
                 phase_id, light, green_onehot, phase_change, e.ph, e.lt, e.oh, e.pc);
      end
    end
    demand = 4'b0010;
    push(2'd0, GRN, 1'b0, 3);
    push(2'd0, YEL, 1'b0, 2);
    while (sb.size() > 0) begin
      @(posedge clk); #1;
      e = sb.pop_front();
      checks++;
      if ({phase_id, light, green_onehot, phase_change} !== e) begin
        errors++;
        $display("[TB] FAIL pre_reset: got ph=%0d light=%b oh=%b pc=%b, want ph=%0d light=%b oh=%b pc=%b",
                 phase_id, light, green_onehot, phase_change, e.ph, e.lt, e.oh, e.pc);
      end
    end
    rst = 1'b1;
    push(2'd0, GRN, 1'b0, 1);
    @(posedge clk); #1;
    e = sb.pop_front();
    checks++;
    if ({phase_id, light, green_onehot, phase_change} !== e) begin
      errors++;
      $display("[TB] FAIL reset_mid_yellow: got ph=%0d light=%b oh=%b pc=%b, want ph=%0d light=%b oh=%b pc=%b",
               phase_id, light, green_onehot, phase_change, e.ph, e.lt, e.oh, e.pc);
    end
    rst = 1'b0;
  endtask

`ifdef PREEMPT_EN
  task automatic test_preempt();
    exp_t e;
    do_reset(4'b0000, 4'b0000);
    push(2'd0, GRN, 1'b0, 1);
    @(posedge clk); #1;
    e = sb.pop_front();
    checks++;
    if ({phase_id, light, green_onehot, phase_change} !== e) begin
      errors++;
      $display("[TB] FAIL preempt_start: got ph=%0d light=%b, want ph=%0d light=%b", phase_id, light, e.ph, e.lt);
    end
    preempt_req   = 1'b1;
    preempt_phase = 2'd2;
    demand        = 4'b1000;
    push(2'd0, YEL, 1'b0, 3);
    push(2'd0, RED, 1'b0, 1);
    push(2'd2, GRN, 1'b1, 5);
    while (sb.size() > 0) begin
      @(posedge clk); #1;
      e = sb.pop_front();
      checks++;
      if ({phase_id, light, green_onehot, phase_change} !== e || preempt_active !== 1'b1) begin
        errors++;
        $display("[TB] FAIL preempt_hold: got ph=%0d light=%b oh=%b pc=%b act=%b, want ph=%0d light=%b oh=%b pc=%b act=1",
                 phase_id, light, green_onehot, phase_change, preempt_active, e.ph, e.lt, e.oh, e.pc);
      end
    end
    preempt_req = 1'b0;
    push(2'd2, YEL, 1'b0, 1);
    @(posedge clk); #1;
    e = sb.pop_front();
    checks++;
    if ({phase_id, light, green_onehot, phase_change} !== e || preempt_active !== 1'b0) begin
      errors++;
      $display("[TB] FAIL preempt_release: got ph=%0d light=%b act=%b, want ph=%0d light=%b act=0",
               phase_id, light, preempt_active, e.ph, e.lt);
    end
  endtask
`endif

  initial begin
    rst     = 1'b1;
    demand  = 4'b0000;
    congest = 4'b0000;
`ifdef PREEMPT_EN
    preempt_req   = 1'b0;
    preempt_phase = 2'd0;
`endif
    $display("[TB] starting adaptive_phase_controller bench");
    test_reset();
    test_skip_empty();
    test_max_cap();
    test_rest_late_demand();
    test_wrap_reset();
`ifdef PREEMPT_EN
    test_preempt();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
